dm_slave_arbiter: RTL
=====================

# dm_slave_arbiter

Two-host arbiter in front of the debug module's single slave port. It shares that port between the core's device-bus data path (0xCD00_0000 window) and the core's debug-mode instruction fetch path. It also produces the per-host grant, response-valid, read-data and error signals. Fixed priority to the data host, with a starvation guard that forces one instruction-fetch grant after `STARVE_LIMIT` consecutive losses.

## Interface
Parameters:
- `XLEN`, 32, bus data/address width
- `WIN_BASE`, 32'hCD00_0000, debug window base address
- `WIN_MASK`, 32'hFFFF_0000, window mask (64 KiB)
- `STARVE_LIMIT`, 4, consecutive instruction-host losses before it is forced to win (≥1)

Ports:
- `clk`  in  1  clock
- `rst_ni`  in  1  reset: asynchronous, active-low
- `d_req_i`  in  1  data-host request; held until `d_gnt_o`
- `d_we_i`  in  1  data-host write
- `d_addr_i`  in  XLEN  data-host byte address
- `d_be_i`  in  XLEN/8  data-host byte enables
- `d_wdata_i`  in  XLEN  data-host write data
- `d_gnt_o`  out  1  data-host grant (combinational)
- `d_rvalid_o`  out  1  data-host response valid (read data or write ack)
- `d_err_o`  out  1  data-host out-of-window error, qualifies `d_rvalid_o`
- `d_rdata_o`  out  XLEN  data-host read data
- `i_req_i`  in  1  instruction-host read request; held until `i_gnt_o`
- `i_addr_i`  in  XLEN  instruction-host address
- `i_gnt_o`  out  1  instruction-host grant (combinational)
- `i_rvalid_o`  out  1  instruction-host response valid
- `i_err_o`  out  1  instruction-host error
- `i_rdata_o`  out  XLEN  instruction-host read data
- `s_req_o`  out  1  slave request
- `s_we_o`  out  1  slave write
- `s_addr_o`  out  XLEN  slave address
- `s_be_o`  out  XLEN/8  slave byte enables
- `s_wdata_o`  out  XLEN  slave write data
- `s_rdata_i`  in  XLEN  slave read data; valid the cycle after `s_req_o`

## Operation
- **Enable flop `en_q`.** Resets to 0 and is set to 1 on the first clock after `rst_ni` deasserts. Both grants are gated by `en_q`, so there are no grants during reset or in the first cycle after it.
- **Winner selection (each cycle, with `en_q` = 1):**
  - Only one host requests: that host wins.
  - Both request: data wins, unless `starve_q == STARVE_LIMIT`, in which case instruction wins.
- **Starvation counter `starve_q`.** Width is clog2(`STARVE_LIMIT`+1); resets to 0.
  - Increments, saturating, when both hosts request and data wins.
  - Clears when the instruction host is granted or `i_req_i` = 0.
  - Holds otherwise.
- **Window check.** `hit` = (`addr` & `WIN_MASK`) == `WIN_BASE`, evaluated on the winner's address.
- **Slave drive.** `s_req_o` = granted & `hit`. `s_we_o` = `d_we_i` when data wins, 0 when instruction wins. Address, byte enables and write data are muxed from the winner. When instruction wins, `s_be_o` is all ones and `s_wdata_o` is 0.
- **Response registers.** All reset to 0: `rsp_v_q`, `rsp_own_q` (0 = data, 1 = instruction), `rsp_err_q` (= ~`hit`) and `rsp_we_q`. They are loaded on every grant and cleared when there is no grant.
- **Response outputs (cycle after a grant):**
  - `x_rvalid_o` = `rsp_v_q` & owner match.
  - `x_err_o` = `rvalid` & `rsp_err_q`.
  - `x_rdata_o` = `s_rdata_i` only for a non-error read by the owner; otherwise 0 (write acks, errors, non-owner).
- **Dropped requests.** A request dropped before grant is ignored and produces no response.

## Timing
- Grant is same-cycle combinational from `req`. Response arrives exactly 1 cycle after grant, for in-window and out-of-window requests alike.
- Fully pipelined: one grant per cycle, back-to-back; a response and a new grant can occur in the same cycle.
- At most one grant per cycle; `d_gnt_o` & `i_gnt_o` is never 1.
- **Reset values:** all `*_rvalid_o`, `*_err_o`, `*_rdata_o` = 0; `s_req_o` = 0; `s_we_o` = 0; grants = 0 (via `en_q`).
- **Reset mid-transfer:** the pending response is discarded; no `rvalid` follows reset release.
- **Starvation bound:** with both hosts requesting continuously, the instruction host is granted at least once every `STARVE_LIMIT`+1 cycles.

## Test plan
- **Reset behaviour.** Hold `rst_ni`=0 with both requests high; release. Required: all outputs 0 during reset and in the first cycle after release; first grant on cycle 2, to the data host.
- **Single data read.** `d_req_i`=1, `d_addr_i`=0xCD00_0010, slave returns 0xDEAD_BEEF. Required: `d_gnt_o` and `s_req_o` in cycle N; `d_rvalid_o`=1 with `d_rdata_o`=0xDEAD_BEEF in N+1; `i_rvalid_o`=0.
- **Data write ack.** `d_we_i`=1, `d_be_i`=4'b0011, `d_wdata_i`=0x1234_5678. Required: slave sees the same values in N; `d_rvalid_o`=1, `d_rdata_o`=0, `d_err_o`=0 in N+1.
- **Starvation guard.** Both hosts request continuously, `STARVE_LIMIT`=4. Required: grant sequence D,D,D,D,I,D,D,D,D,I…; every response is routed to the correct host with no gaps.
- **Out-of-window.** `i_addr_i`=0x0000_1000. Required: `i_gnt_o`=1 with `s_req_o`=0; `i_rvalid_o`=1, `i_err_o`=1, `i_rdata_o`=0 one cycle later.
- **Reset mid-transfer.** Assert `rst_ni`=0 in the cycle after a grant. Required: no `rvalid` is ever emitted for that request.

Source files
------------

// File: rtl/dm_slave_arbiter.sv
// Shares the debug module slave port between the data host (priority) and the instruction-fetch host.
// Grants are combinational and the response follows 1 cycle later. There is no backpressure: one grant per cycle, and a starvation guard protects the fetch host.
module dm_slave_arbiter #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] WIN_BASE     = 32'hCD00_0000,
   parameter logic [XLEN-1:0] WIN_MASK     = 32'hFFFF_0000,
   parameter int unsigned     STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [XLEN-1:0]   d_addr_i,
   input  logic [XLEN/8-1:0] d_be_i,
   input  logic [XLEN-1:0]   d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic              d_err_o,
   output logic [XLEN-1:0]   d_rdata_o,
   input  logic              i_req_i,
   input  logic [XLEN-1:0]   i_addr_i,
   output logic              i_gnt_o,
   output logic              i_rvalid_o,
   output logic              i_err_o,
   output logic [XLEN-1:0]   i_rdata_o,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [XLEN-1:0]   s_addr_o,
   output logic [XLEN/8-1:0] s_be_o,
   output logic [XLEN-1:0]   s_wdata_o,
   input  logic [XLEN-1:0]   s_rdata_i
);

   localparam int unsigned   SW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   logic          r_en;
   logic [SW-1:0] r_starve;
   logic          r_rsp_v;
   logic          r_rsp_own;
   logic          r_rsp_err;
   logic          r_rsp_we;

   logic            w_d_win;
   logic            w_i_win;
   logic            w_gnt;
   logic            w_hit;
   logic [XLEN-1:0] w_addr;

   // Data host wins ties unless the fetch host has lost STARVE_LIMIT times in a row
   always_comb begin
      w_d_win = r_en & d_req_i & ~(i_req_i & (r_starve == LIM));
      w_i_win = r_en & i_req_i & ~w_d_win;
      w_gnt   = w_d_win | w_i_win;
      w_addr  = w_i_win ? i_addr_i : d_addr_i;
      w_hit   = (w_addr & WIN_MASK) == WIN_BASE;
   end

   assign d_gnt_o   = w_d_win;
   assign i_gnt_o   = w_i_win;
   assign s_req_o   = w_gnt & w_hit;
   assign s_we_o    = w_d_win & d_we_i;
   assign s_addr_o  = w_addr;
   assign s_be_o    = w_i_win ? {(XLEN/8){1'b1}} : d_be_i;
   assign s_wdata_o = w_i_win ? '0 : d_wdata_i;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en      <= 1'b0;
         r_starve  <= '0;
         r_rsp_v   <= 1'b0;
         r_rsp_own <= 1'b0;
         r_rsp_err <= 1'b0;
         r_rsp_we  <= 1'b0;
      end else begin
         r_en <= 1'b1;
         if (w_i_win || !i_req_i) begin
            r_starve <= '0;
         end else if (w_d_win && (r_starve != LIM)) begin
            r_starve <= r_starve + SW'(1);
         end
         r_rsp_v   <= w_gnt;
         r_rsp_own <= w_i_win;
         r_rsp_err <= w_gnt & ~w_hit;
         r_rsp_we  <= w_d_win & d_we_i;
      end
   end

   // Read data is passed only to the owner of a clean read; acks and errors return zero
   assign d_rvalid_o = r_rsp_v & ~r_rsp_own;
   assign i_rvalid_o = r_rsp_v & r_rsp_own;
   assign d_err_o    = d_rvalid_o & r_rsp_err;
   assign i_err_o    = i_rvalid_o & r_rsp_err;
   assign d_rdata_o  = (d_rvalid_o & ~r_rsp_err & ~r_rsp_we) ? s_rdata_i : '0;
   assign i_rdata_o  = (i_rvalid_o & ~r_rsp_err) ? s_rdata_i : '0;

endmodule
